// File: rtl/mips_mult_pipe.sv
// mips_mult_pipe: four-stage pipelined 32x32 multiplier (P0..P3) with a
// write-back stage W that writes LO to a GPR and updates architectural HI/LO.
module mips_mult_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mult_start_D,
  input  logic                  mult_signed_D,
  input  logic [DATA_W-1:0]     src_a_D,
  input  logic [DATA_W-1:0]     src_b_D,
  input  logic [REG_ADDR_W-1:0] reg_dest_addr_D,
  input  logic                  stall,
  input  logic                  flush,
  output logic [3:0]            mult_valid_P,
  output logic                  mult_start_P1,
  output logic [REG_ADDR_W-1:0] reg_dest_addr_mult,
  output logic                  mult_busy,
  output logic                  mult_wr_en_W,
  output logic [REG_ADDR_W-1:0] mult_wr_addr_W,
  output logic [DATA_W-1:0]     mult_wr_data_W,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  logic                  accept;

  // Per-stage state
  logic [3:0]            valid_q, valid_d;
  logic [3:0]            neg_q, neg_d;
  logic [REG_ADDR_W-1:0] dest_q [4];
  logic [REG_ADDR_W-1:0] dest_d [4];

  // P0 operand magnitudes
  logic [DATA_W-1:0]     mag_a_q, mag_a_d;
  logic [DATA_W-1:0]     mag_b_q, mag_b_d;

  // P1 partial products
  logic [DATA_W-1:0]     pp_ll_q, pp_ll_d;
  logic [DATA_W-1:0]     pp_lh_q, pp_lh_d;
  logic [DATA_W-1:0]     pp_hl_q, pp_hl_d;
  logic [DATA_W-1:0]     pp_hh_q, pp_hh_d;

  // P2 unsigned product, P3 signed-corrected product
  logic [PROD_W-1:0]     sum_q, sum_d;
  logic [PROD_W-1:0]     prod_q, prod_d;

  // W stage
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [DATA_W-1:0]     hi_d, lo_d;
  logic [REG_ADDR_W-1:0] dest_mult_q, dest_mult_d;

  assign accept = mult_start_D & ~stall & ~rst;

  // Next-state for every stage; operands are zeroed when not accepted so
  // undriven Decode operands never leak into the datapath.
  always_comb begin
    valid_d     = '0;
    neg_d       = '0;
    mag_a_d     = '0;
    mag_b_d     = '0;
    dest_d[0]   = '0;
    dest_mult_d = dest_mult_q;

    if (accept) begin
      valid_d[0]  = 1'b1;
      neg_d[0]    = mult_signed_D & (src_a_D[DATA_W-1] ^ src_b_D[DATA_W-1]);
      mag_a_d     = (mult_signed_D & src_a_D[DATA_W-1]) ? (~src_a_D + 1'b1) : src_a_D;
      mag_b_d     = (mult_signed_D & src_b_D[DATA_W-1]) ? (~src_b_D + 1'b1) : src_b_D;
      dest_d[0]   = reg_dest_addr_D;
      dest_mult_d = reg_dest_addr_D;
    end

    valid_d[1] = valid_q[0] & ~flush;
    valid_d[2] = valid_q[1];
    valid_d[3] = valid_q[2];
    neg_d[3:1] = neg_q[2:0];
    dest_d[1]  = dest_q[0];
    dest_d[2]  = dest_q[1];
    dest_d[3]  = dest_q[2];

    pp_ll_d = mag_a_q[HALF_W-1:0]      * mag_b_q[HALF_W-1:0];
    pp_lh_d = mag_a_q[HALF_W-1:0]      * mag_b_q[DATA_W-1:HALF_W];
    pp_hl_d = mag_a_q[DATA_W-1:HALF_W] * mag_b_q[HALF_W-1:0];
    pp_hh_d = mag_a_q[DATA_W-1:HALF_W] * mag_b_q[DATA_W-1:HALF_W];

    sum_d = {{DATA_W{1'b0}}, pp_ll_q}
          + ({{DATA_W{1'b0}}, pp_lh_q} << HALF_W)
          + ({{DATA_W{1'b0}}, pp_hl_q} << HALF_W)
          + ({{DATA_W{1'b0}}, pp_hh_q} << DATA_W);

    prod_d = neg_q[2] ? (~sum_q + 1'b1) : sum_q;

    wr_en_d   = valid_q[3];
    wr_addr_d = dest_q[3];
    wr_data_d = prod_q[DATA_W-1:0];
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (valid_q[3]) begin
      hi_d = prod_q[PROD_W-1:DATA_W];
      lo_d = prod_q[DATA_W-1:0];
    end
  end

  // Pipeline registers advance every cycle; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      neg_q       <= '0;
      for (int i = 0; i < 4; i++) dest_q[i] <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      pp_ll_q     <= '0;
      pp_lh_q     <= '0;
      pp_hl_q     <= '0;
      pp_hh_q     <= '0;
      sum_q       <= '0;
      prod_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dest_mult_q <= '0;
    end else begin
      valid_q     <= valid_d;
      neg_q       <= neg_d;
      for (int i = 0; i < 4; i++) dest_q[i] <= dest_d[i];
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      pp_ll_q     <= pp_ll_d;
      pp_lh_q     <= pp_lh_d;
      pp_hl_q     <= pp_hl_d;
      pp_hh_q     <= pp_hh_d;
      sum_q       <= sum_d;
      prod_q      <= prod_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dest_mult_q <= dest_mult_d;
    end
  end

  assign mult_valid_P       = valid_q;
  assign mult_start_P1      = valid_q[1];
  assign reg_dest_addr_mult = dest_mult_q;
  assign mult_busy          = (|valid_q) | wr_en_q;
  assign mult_wr_en_W       = wr_en_q;
  assign mult_wr_addr_W     = wr_addr_q;
  assign mult_wr_data_W     = wr_data_q;

endmodule
